// File: rtl/ecc_pkg.sv
// ECC core shared definitions: sequencer states,
// sign status codes and the operand RAM slot map.
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KREQ = 3'd1,
    ST_PM   = 3'd2,
    ST_RCAL = 3'd3,
    ST_ICAL = 3'd4,
    ST_SCAL = 3'd5,
    ST_FIN  = 3'd6
  } seq_state_e;

  localparam logic [1:0] STS_OK    = 2'b00;
  localparam logic [1:0] STS_RETRY = 2'b01;
  localparam logic [1:0] STS_TMO   = 2'b10;

  localparam logic [3:0] K_NUM = 4'd0;
  localparam logic [3:0] X_KG  = 4'd1;
  localparam logic [3:0] R_NUM = 4'd2;
  localparam logic [3:0] K_INV = 4'd3;
  localparam logic [3:0] S_NUM = 4'd4;

  // states that run a downstream step under the watchdog
  function automatic logic is_step(seq_state_e s);
    return s inside {ST_KREQ, ST_PM, ST_RCAL,
                     ST_ICAL, ST_SCAL};
  endfunction

endpackage

// File: rtl/ecdsa_sign_seq_if.sv
// Handshake bundle between the sign sequencer and
// the nonce source / point-mult / r-s-inverse units.
interface ecdsa_sign_seq_if;
  logic k_req;
  logic k_ack;
  logic pm_start;
  logic pm_done;
  logic acen_r;
  logic acen_i;
  logic acen_s;
  logic rsidone;
  logic res_zero;

  modport master (
    output k_req, pm_start,
    output acen_r, acen_i, acen_s,
    input  k_ack, pm_done,
    input  rsidone, res_zero
  );

  modport slave (
    input  k_req, pm_start,
    input  acen_r, acen_i, acen_s,
    output k_ack, pm_done,
    output rsidone, res_zero
  );
endinterface

// File: rtl/ecc_step_wdt.sv
// Per-step watchdog: counts cycles in a step and
// flags expiry on the cycle the count reaches TMO.
module ecc_step_wdt #(
  parameter int TMO = 65535,
  parameter int TMW = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TMW-1:0] LAST = TMW'(TMO - 1);

  logic [TMW-1:0] cnt_q, cnt_d;

  // clear on step change, count while enabled, hold at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/ecdsa_sign_seq.sv
// ECDSA sign sequencer: nonce, k*G, r, k^-1, s with
// nonce retry on zero r/s and a per-step watchdog.
module ecdsa_sign_seq
  import ecc_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int RCW       = 2,
  parameter int TMO       = 65535,
  parameter int TMW       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  ecdsa_sign_seq_if.master ctl,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [RCW-1:0]   retries
);
  seq_state_e     state_q, state_d;
  logic [1:0]     status_q, status_d;
  logic [RCW-1:0] retries_q, retries_d;
  logic k_req_q, k_req_d;
  logic pm_start_q, pm_start_d;
  logic acen_r_q, acen_r_d;
  logic acen_i_q, acen_i_d;
  logic acen_s_q, acen_s_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic retry, wdt_clr, wdt_en, wdt_exp;

  assign wdt_en = is_step(state_q);

  ecc_step_wdt #(
    .TMO (TMO),
    .TMW (TMW)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (wdt_exp)
  );

  // step sequencing; a completion seen together with
  // its own start pulse is stale and ignored
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    retries_d = retries_q;
    retry     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_KREQ;
        status_d  = STS_OK;
        retries_d = '0;
      end
      ST_KREQ: begin
        if (ctl.k_ack) state_d = ST_PM;
        else if (wdt_exp) state_d = ST_FIN;
      end
      ST_PM: begin
        if (ctl.pm_done && !pm_start_q)
          state_d = ST_RCAL;
        else if (wdt_exp) state_d = ST_FIN;
      end
      ST_RCAL: begin
        if (ctl.rsidone && !acen_r_q) begin
          if (ctl.res_zero) retry = 1'b1;
          else state_d = ST_ICAL;
        end else if (wdt_exp) state_d = ST_FIN;
      end
      ST_ICAL: begin
        if (ctl.rsidone && !acen_i_q)
          state_d = ST_SCAL;
        else if (wdt_exp) state_d = ST_FIN;
      end
      ST_SCAL: begin
        if (ctl.rsidone && !acen_s_q) begin
          if (ctl.res_zero) retry = 1'b1;
          else state_d = ST_FIN;
        end else if (wdt_exp) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // a step leaving straight to FIN did so on expiry
    if (is_step(state_q) && state_d == ST_FIN)
      status_d = STS_TMO;
    if (state_q == ST_SCAL && state_d == ST_FIN
        && ctl.rsidone && !acen_s_q)
      status_d = STS_OK;
    if (retry) begin
      if (retries_q == RCW'(MAX_RETRY)) begin
        state_d  = ST_FIN;
        status_d = STS_RETRY;
      end else begin
        state_d   = ST_KREQ;
        retries_d = retries_q + 1'b1;
      end
    end
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      status_d  = status_q;
      retries_d = retries_q;
    end
  end

  // registered outputs, pulses on the first cycle of a state
  always_comb begin
    k_req_d    = state_d == ST_KREQ;
    pm_start_d = state_d == ST_PM   && state_q != ST_PM;
    acen_r_d   = state_d == ST_RCAL && state_q != ST_RCAL;
    acen_i_d   = state_d == ST_ICAL && state_q != ST_ICAL;
    acen_s_d   = state_d == ST_SCAL && state_q != ST_SCAL;
    busy_d     = state_d != ST_IDLE;
    done_d     = state_d == ST_FIN;
    wdt_clr    = state_d != state_q;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      status_q   <= STS_OK;
      retries_q  <= '0;
      k_req_q    <= 1'b0;
      pm_start_q <= 1'b0;
      acen_r_q   <= 1'b0;
      acen_i_q   <= 1'b0;
      acen_s_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      retries_q  <= retries_d;
      k_req_q    <= k_req_d;
      pm_start_q <= pm_start_d;
      acen_r_q   <= acen_r_d;
      acen_i_q   <= acen_i_d;
      acen_s_q   <= acen_s_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ctl.k_req    = k_req_q;
  assign ctl.pm_start = pm_start_q;
  assign ctl.acen_r   = acen_r_q;
  assign ctl.acen_i   = acen_i_q;
  assign ctl.acen_s   = acen_s_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign status       = status_q;
  assign retries      = retries_q;
endmodule

// File: tb/tb_ecdsa_sign_seq.sv
// Bench for ecdsa_sign_seq: randomized responder timing
// and zero outcomes checked against a pass-level model.
module tb_ecdsa_sign_seq;
  localparam int MR  = 3;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic busy, done;
  logic [1:0] status;
  logic [1:0] retries;

  ecdsa_sign_seq_if ctl ();

  ecdsa_sign_seq #(
    .MAX_RETRY (MR),
    .RCW       (2),
    .TMO       (TMO),
    .TMW       (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .ctl     (ctl),
    .busy    (busy),
    .done    (done),
    .status  (status),
    .retries (retries)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic rep_i(input string tag, input bit ok,
                       input longint o, input longint e);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, o, e);
    end
  endtask

  task automatic rep_s(input string tag, input bit ok,
                       input string o, input string e);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s: observed=%s expected=%s",
             tag, o, e);
    end
  endtask

  int kack_dly = 2;
  int pm_dly   = 10;
  int rsi_dly  = 5;
  bit zr_r [8];
  bit zr_s [8];
  int inj_req = 0;

  int k_at, p_at, r_at, r_kind, pass, last_rsi, inj_seen;
  bit kq_r;
  initial begin
    ctl.k_ack = 0; ctl.pm_done = 0;
    ctl.rsidone = 0; ctl.res_zero = 0;
    k_at = -1; p_at = -1; r_at = -1; r_kind = 0;
    pass = 0; last_rsi = -1; inj_seen = 0; kq_r = 0;
    forever begin
      @(negedge clk);
      ctl.k_ack = 0; ctl.pm_done = 0;
      ctl.rsidone = 0; ctl.res_zero = 0;
      if (inj_req != inj_seen) begin
        ctl.rsidone = 1; ctl.res_zero = 1;
        inj_seen = inj_req;
      end
      if (rst || !busy) begin
        k_at = -1; p_at = -1; r_at = -1; pass = 0;
      end else begin
        if (ctl.k_req && !kq_r) k_at = cyc + kack_dly;
        if (ctl.pm_start && pm_dly >= 0)
          p_at = cyc + pm_dly;
        if (ctl.acen_r) begin r_at = cyc + rsi_dly; r_kind = 0; end
        if (ctl.acen_i) begin r_at = cyc + rsi_dly; r_kind = 1; end
        if (ctl.acen_s) begin r_at = cyc + rsi_dly; r_kind = 2; end
        if (cyc == k_at) ctl.k_ack = 1;
        if (cyc == p_at) ctl.pm_done = 1;
        if (cyc == r_at) begin
          ctl.rsidone = 1;
          last_rsi = cyc;
          case (r_kind)
            0: ctl.res_zero = zr_r[pass];
            1: ctl.res_zero = 1'($urandom);
            default: ctl.res_zero = zr_s[pass];
          endcase
          if (r_kind != 1 && ctl.res_zero) pass++;
        end
      end
      kq_r = ctl.k_req;
    end
  end

  byte evq[$];
  int ovl = 0, ndone = 0;
  int pm_cyc = -1, r_cyc = -1, done_cyc = -1;
  bit kq_m = 0;
  always @(negedge clk) begin
    if (ctl.k_req && !kq_m) evq.push_back("K");
    kq_m = ctl.k_req;
    if (ctl.pm_start) begin evq.push_back("P"); pm_cyc = cyc; end
    if (ctl.acen_r) begin evq.push_back("R"); r_cyc = cyc; end
    if (ctl.acen_i) evq.push_back("I");
    if (ctl.acen_s) evq.push_back("S");
    if (done) begin
      evq.push_back("D"); done_cyc = cyc; ndone++;
    end
    if (int'(ctl.pm_start) + int'(ctl.acen_r)
        + int'(ctl.acen_i) + int'(ctl.acen_s) > 1)
      ovl++;
  end

  function automatic string ev_str();
    string s = "";
    foreach (evq[i]) s = $sformatf("%s%c", s, evq[i]);
    return s;
  endfunction

  string exp_s;
  int exp_st, exp_rt;
  task automatic model();
    exp_s = ""; exp_st = 0; exp_rt = 0;
    for (int p = 0; p <= MR; p++) begin
      exp_s = {exp_s, "KPR"};
      if (zr_r[p]) begin
        if (p == MR) begin exp_st = 1; break; end
        exp_rt++;
        continue;
      end
      exp_s = {exp_s, "IS"};
      if (zr_s[p]) begin
        if (p == MR) begin exp_st = 1; break; end
        exp_rt++;
        continue;
      end
      break;
    end
    exp_s = {exp_s, "D"};
  endtask

  task automatic wait_sig(input byte which,
                          input string tag);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 1000) begin
      @(negedge clk);
      n++;
      case (which)
        "P": hit = ctl.pm_start;
        "I": hit = ctl.acen_i;
        "S": hit = ctl.acen_s;
        default: hit = done;
      endcase
    end
    rep_i(tag, hit === 1'b1, hit, 1);
  endtask

  task automatic begin_run(input string tag);
    model();
    evq.delete();
    done_cyc = -1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    rep_i({tag, "_startlat"},
          {busy, ctl.k_req} === 2'b11,
          {busy, ctl.k_req}, 3);
  endtask

  task automatic end_run(input string tag);
    string s;
    wait_sig("D", {tag, "_done"});
    @(negedge clk);
    rep_i({tag, "_busylow"}, busy === 1'b0, busy, 0);
    s = ev_str();
    rep_s({tag, "_seq"}, s == exp_s, s, exp_s);
    rep_i({tag, "_status"}, status === 2'(exp_st),
          status, exp_st);
    rep_i({tag, "_retries"}, retries === 2'(exp_rt),
          retries, exp_rt);
    if (exp_st == 0)
      rep_i({tag, "_donelat"},
            done_cyc === last_rsi + 1,
            done_cyc, last_rsi + 1);
    rep_i({tag, "_onehot"}, ovl === 0, ovl, 0);
  endtask

  task automatic clr_zr();
    for (int i = 0; i < 8; i++) begin
      zr_r[i] = 0; zr_s[i] = 0;
    end
  endtask

  task automatic rnd_dly();
    kack_dly = $urandom_range(6, 1);
    pm_dly   = $urandom_range(15, 3);
    rsi_dly  = $urandom_range(10, 3);
  endtask

  int nd;
  string sq;
  logic [12:0] outs;
  initial begin
    rst = 1; start = 0; abort = 0;
    clr_zr();
    repeat (3) @(negedge clk);
    outs = {busy, done, ctl.k_req, ctl.pm_start,
            ctl.acen_r, ctl.acen_i, ctl.acen_s,
            status, retries};
    rep_i("reset_outs", outs === 13'd0, outs, 0);
    rst = 0;

    kack_dly = 2; pm_dly = 10; rsi_dly = 5;
    begin_run("nominal");
    end_run("nominal");

    rnd_dly();
    zr_r[0] = 1;
    begin_run("zero_r");
    end_run("zero_r");

    clr_zr(); rnd_dly();
    for (int i = 0; i < 8; i++) zr_s[i] = 1;
    begin_run("exhaust");
    end_run("exhaust");

    for (int t = 0; t < 6; t++) begin
      rnd_dly();
      for (int i = 0; i < 8; i++) begin
        zr_r[i] = ($urandom_range(3, 0) == 0);
        zr_s[i] = ($urandom_range(3, 0) == 0);
      end
      begin_run($sformatf("rand%0d", t));
      end_run($sformatf("rand%0d", t));
    end

    clr_zr(); rnd_dly();
    pm_dly = -1;
    begin_run("tmo");
    exp_s = "KPD"; exp_st = 2; exp_rt = 0;
    end_run("tmo");
    rep_i("tmo_cycles", done_cyc === pm_cyc + TMO,
          done_cyc, pm_cyc + TMO);

    rnd_dly();
    pm_dly = TMO - 1;
    begin_run("tmo_edge");
    end_run("tmo_edge");
    rep_i("tmo_edge_rcal", r_cyc === pm_cyc + TMO,
          r_cyc, pm_cyc + TMO);

    rnd_dly();
    begin_run("abort");
    wait_sig("I", "abort_wait_i");
    nd = ndone;
    abort = 1;
    @(negedge clk);
    abort = 0;
    rep_i("abort_busy", {busy, done} === 2'b00,
          {busy, done}, 0);
    repeat (30) @(negedge clk);
    sq = ev_str();
    rep_s("abort_seq", sq == "KPRI", sq, "KPRI");
    rep_i("abort_nodone", ndone === nd, ndone, nd);

    rnd_dly();
    zr_r[0] = 1;
    begin_run("rst_mid");
    wait_sig("S", "rst_wait_s");
    rep_i("rst_mid_retries", retries === 2'd1,
          retries, 1);
    rst = 1;
    @(negedge clk);
    outs = {busy, done, ctl.k_req, ctl.pm_start,
            ctl.acen_r, ctl.acen_i, ctl.acen_s,
            status, retries};
    rep_i("rst_mid_outs", outs === 13'd0, outs, 0);
    rst = 0;
    clr_zr();
    kack_dly = 2; pm_dly = 10; rsi_dly = 5;
    begin_run("after_rst");
    end_run("after_rst");

    pm_dly = 12;
    begin_run("illegal");
    wait_sig("P", "illegal_wait_p");
    repeat (3) @(negedge clk);
    start = 1;
    inj_req++;
    @(negedge clk);
    start = 0;
    end_run("illegal");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench time limit hit");
    $fatal(1);
  end
endmodule
